// File: rtl/c880_bist_pkg.sv
// Shared definitions for the C880 BIST capture path: FSM state encoding,
// default widths and the default MISR polynomial/seed.
package c880_bist_pkg;

  // Response word width: one bit per C880 primary output.
  localparam int RESP_W_DEF = 26;
  // Pattern counter width: holds a 5000-pattern run.
  localparam int CNT_W_DEF  = 13;

  // x^26 + x^6 + x^2 + x + 1; the x^26 term is implicit (shifted-out MSB).
  localparam logic [RESP_W_DEF-1:0] POLY_DEF = 26'h0000047;
  localparam logic [RESP_W_DEF-1:0] SEED_DEF = 26'h0000000;

  // Run sequencing states.
  // state    | meaning
  // ST_IDLE  | out of reset, waiting for the first start
  // ST_RUN   | accepting and compacting response words
  // ST_CHECK | final signature compared against golden value
  // ST_DONE  | result held until the next start
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

endpackage

// File: rtl/c880_resp_compactor_misr_step.sv
// One combinational MISR step: shift left, fold the shifted-out MSB back in
// through the feedback taps, then XOR the incoming word. Shared with the
// pattern-source LFSR (which drives data_i with zero).
module misr_step #(
  parameter int             W    = 26,
  parameter logic [W-1:0]   POLY = 26'h0000047
) (
  input  logic [W-1:0] sig_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sig_o
);

  logic [W-1:0] shifted;
  logic [W-1:0] feedback;

  // Galois-style shift with feedback selected by the outgoing MSB.
  always_comb begin
    shifted  = {sig_i[W-2:0], 1'b0};
    feedback = sig_i[W-1] ? POLY : '0;
    sig_o    = shifted ^ feedback ^ data_i;
  end

endmodule

// File: rtl/c880_resp_compactor.sv
// BIST response compactor for the C880 ALU under test. Folds one response
// word per handshake into a MISR, then compares the final signature with a
// golden value after the programmed number of patterns.
// Optional feature macro: RESP_XMASK_EN adds resp_mask; masked bits are
// forced to zero before compaction so unknown CUT outputs cannot corrupt
// the signature.
module c880_resp_compactor
  import c880_bist_pkg::*;
#(
  parameter int                  RESP_W = RESP_W_DEF,
  parameter int                  CNT_W  = CNT_W_DEF,
  parameter logic [RESP_W-1:0]   POLY   = POLY_DEF,
  parameter logic [RESP_W-1:0]   SEED   = SEED_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [RESP_W-1:0] golden_sig,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [RESP_W-1:0] resp_data,
`ifdef RESP_XMASK_EN
  input  logic [RESP_W-1:0] resp_mask,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [RESP_W-1:0] signature,
  output logic [CNT_W-1:0]  count
);

  bist_state_e       state_q;
  logic [RESP_W-1:0] sig_q;
  logic [RESP_W-1:0] sig_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  n_q;
  logic              pass_q;
  logic [RESP_W-1:0] data_eff;
  logic              accept;
  logic              last_accept;

  // Word actually folded into the signature (X-masked when enabled).
`ifdef RESP_XMASK_EN
  assign data_eff = resp_data & ~resp_mask;
`else
  assign data_eff = resp_data;
`endif

  misr_step #(
    .W    (RESP_W),
    .POLY (POLY)
  ) u_misr_step (
    .sig_i  (sig_q),
    .data_i (data_eff),
    .sig_o  (sig_d)
  );

  // Handshake and run-length decode. resp_ready comes from state alone so
  // the CUT side never sees a combinational loop through resp_valid.
  assign resp_ready  = (state_q == ST_RUN);
  assign accept      = resp_valid && resp_ready;
  assign cnt_d       = cnt_q + CNT_W'(1);
  assign last_accept = accept && (cnt_d == n_q);

  // Run sequencer: start handling, compaction, count and final compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      n_q     <= '0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            n_q     <= num_patterns;
            // Zero-length run skips straight to the compare on SEED.
            state_q <= (num_patterns == '0) ? ST_CHECK : ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
          end
          if (last_accept) begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          pass_q  <= (sig_q == golden_sig);
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs decoded from the state register.
  assign busy      = (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign signature = sig_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_c880_resp_compactor.sv
// Self-checking bench for c880_resp_compactor: directed cases plus
// randomized runs compared against a polynomial-arithmetic signature model.
module tb_c880_resp_compactor;

  localparam logic [25:0] POLY = 26'h0000047;
  localparam logic [25:0] SEED = 26'h0000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [12:0] num_patterns;
  logic [25:0] golden_sig;
  logic        resp_valid;
  logic        resp_ready;
  logic [25:0] resp_data;
  logic [25:0] resp_mask;
  logic        busy;
  logic        done;
  logic        pass;
  logic [25:0] signature;
  logic [12:0] count;

  int errors = 0;
  int checks = 0;

  logic [25:0] fixed_w [16];
  logic [25:0] mask_w  [16];

  c880_resp_compactor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_patterns (num_patterns),
    .golden_sig   (golden_sig),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
`ifdef RESP_XMASK_EN
    .resp_mask    (resp_mask),
`endif
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Signature as a polynomial over GF(2): multiply by x, reduce modulo
  // x^26+x^6+x^2+x+1, then add the incoming word.
  function automatic logic [25:0] model_step(input logic [25:0] s, input logic [25:0] d);
    logic [26:0] w;
    w = {1'b0, s} * 27'd2;
    if (w >= 27'h4000000) w = w ^ {1'b1, POLY};
    return w[25:0] ^ d;
  endfunction

  function automatic logic [25:0] model_sig(input int n);
    logic [25:0] s = SEED;
    for (int i = 0; i < n; i++) begin
`ifdef RESP_XMASK_EN
      s = model_step(s, fixed_w[i] & ~mask_w[i]);
`else
      s = model_step(s, fixed_w[i]);
`endif
    end
    return s;
  endfunction

  // One full run using fixed_w[0..n-1]. mode 0: random stalls at stall_pct,
  // mode 1: valid alternates 1,0,1,0,... poke: start asserted during RUN/CHECK.
  task automatic run_seq(input int n, input logic [25:0] gold, input int mode,
                         input int stall_pct, input bit poke, output logic [25:0] sig_out);
    logic [25:0] exp_sig;
    int acc;
    int cyc;
    exp_sig = model_sig(n);
    @(posedge clk); #1;
    start = 1'b1; num_patterns = 13'(n); golden_sig = gold;
    @(posedge clk); #1;
    start = 1'b0; num_patterns = 13'($urandom_range(8191));
    check("start_done_clr", {31'd0, done}, 32'd0);
    check("start_cnt_clr", {19'd0, count}, 32'd0);
    check("start_sig_seed", {6'd0, signature}, {6'd0, SEED});
    check("start_pass_clr", {31'd0, pass}, 32'd0);
    check("start_busy", {31'd0, busy}, 32'd1);
    if (n == 0) begin
      check("zero_ready", {31'd0, resp_ready}, 32'd0);
    end else begin
      acc = 0;
      cyc = 0;
      while (acc < n && cyc < n * 8 + 20) begin
        if (mode == 1) resp_valid = (cyc % 2 == 0);
        else           resp_valid = ($urandom_range(99) >= stall_pct);
        resp_data = fixed_w[acc];
        resp_mask = mask_w[acc];
        if (poke && cyc == 1) begin
          start = 1'b1;
          num_patterns = 13'($urandom_range(1, 8191));
        end
        @(negedge clk);
        check("run_ready", {31'd0, resp_ready}, 32'd1);
        check("run_count", {19'd0, count}, acc);
        @(posedge clk);
        if (resp_valid) acc++;
        #1;
        start = 1'b0;
        resp_valid = 1'b0;
        resp_data = $urandom;
        cyc++;
      end
      if (acc < n) check("run_timeout", acc, n);
      check("check_done_low", {31'd0, done}, 32'd0);
      check("check_busy", {31'd0, busy}, 32'd1);
      check("check_ready_low", {31'd0, resp_ready}, 32'd0);
      if (poke) start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_high", {31'd0, done}, 32'd1);
    check("done_busy_low", {31'd0, busy}, 32'd0);
    check("done_sig", {6'd0, signature}, {6'd0, exp_sig});
    check("done_count", {19'd0, count}, n);
    check("done_pass", {31'd0, pass}, {31'd0, exp_sig == gold});
    // Result must hold in DONE while words are offered.
    resp_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resp_valid = 1'b0;
    check("hold_done", {31'd0, done}, 32'd1);
    check("hold_sig", {6'd0, signature}, {6'd0, exp_sig});
    check("hold_count", {19'd0, count}, n);
    sig_out = exp_sig;
  endtask

  task automatic clear_words();
    for (int i = 0; i < 16; i++) begin
      fixed_w[i] = '0;
      mask_w[i]  = '0;
    end
  endtask

  initial begin
    logic [25:0] s1;
    logic [25:0] s2;
    logic [25:0] g;
    int n;

    rst_n = 1'b0; start = 1'b0; num_patterns = '0; golden_sig = '0;
    resp_valid = 1'b1; resp_data = 26'h3ffffff; resp_mask = '0;
    clear_words();

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, resp_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_sig", {6'd0, signature}, {6'd0, SEED});
    check("rst_count", {19'd0, count}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready", {31'd0, resp_ready}, 32'd0);
    check("idle_count", {19'd0, count}, 32'd0);
    check("idle_sig", {6'd0, signature}, {6'd0, SEED});
    check("idle_done", {31'd0, done}, 32'd0);
    resp_valid = 1'b0;

    // Single pattern
    fixed_w[0] = 26'h0000001;
    run_seq(1, 26'h0000001, 0, 0, 1'b0, s1);
    check("single_sig_const", {6'd0, signature}, 32'h0000001);
    check("single_pass_const", {31'd0, pass}, 32'd1);

    // Feedback through the taps
    fixed_w[0] = 26'h2000000; fixed_w[1] = 26'h0000000;
    run_seq(2, 26'h0000048, 0, 0, 1'b0, s1);
    check("fb_sig_const", {6'd0, signature}, 32'h0000047);
    check("fb_pass_const", {31'd0, pass}, 32'd0);

    // Stalls: same words, with and without gaps, plus ignored starts
    for (int i = 0; i < 3; i++) fixed_w[i] = 26'($urandom);
    run_seq(3, 26'h0, 0, 0, 1'b0, s1);
    run_seq(3, s1, 1, 0, 1'b1, s2);
    check("stall_same_sig", {6'd0, signature}, {6'd0, s1});
    check("stall_pass", {31'd0, pass}, 32'd1);

    // Zero length, then restart from DONE
    run_seq(0, SEED, 0, 0, 1'b0, s1);
    run_seq(0, 26'h0000123, 0, 0, 1'b0, s1);
    fixed_w[0] = 26'h1555555;
    run_seq(1, 26'h1555555, 0, 0, 1'b0, s1);

    // Randomized runs
    for (int r = 0; r < 24; r++) begin
      n = $urandom_range(1, 16);
      for (int i = 0; i < 16; i++) begin
        fixed_w[i] = 26'($urandom);
`ifdef RESP_XMASK_EN
        mask_w[i]  = ($urandom_range(1) == 1) ? 26'($urandom) : 26'h0;
`endif
      end
      g = ($urandom_range(1) == 1) ? model_sig(n) : 26'($urandom);
      run_seq(n, g, 0, $urandom_range(0, 60), ($urandom_range(3) == 0), s1);
    end
    clear_words();

    // Abort: reset after 2 of 5 accepts
    @(posedge clk); #1;
    start = 1'b1; num_patterns = 13'd5; golden_sig = 26'h0;
    @(posedge clk); #1;
    start = 1'b0;
    resp_valid = 1'b1; resp_data = 26'h0abcdef;
    repeat (2) @(posedge clk);
    #1;
    check("abort_pre_count", {19'd0, count}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("abort_sig", {6'd0, signature}, {6'd0, SEED});
    check("abort_count", {19'd0, count}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_ready", {31'd0, resp_ready}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    resp_valid = 1'b0;
    check("abort_no_done", {31'd0, done}, 32'd0);
    check("abort_idle_count", {19'd0, count}, 32'd0);
    check("abort_idle_ready", {31'd0, resp_ready}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
